// File: rtl/alu_operand_collector.sv
// Operand-fetch stage for the SIMD adder: reads 3 or 4 operands over one RF read port.
// Optional ALU_OPC_R0_ZERO_EN makes register 0 read as constant zero.
module alu_operand_collector #(
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_form,
   input  logic [1:0]    req_vec,
   input  logic [AW-1:0] req_ra,
   input  logic [AW-1:0] req_rb,
   input  logic [AW-1:0] req_rc,
   input  logic [AW-1:0] req_rd,
   output logic          rf_en,
   output logic [AW-1:0] rf_addr,
   input  logic [31:0]   rf_rdata,
   output logic          op_valid,
   input  logic          op_ready,
   output logic          op_form,
   output logic [1:0]    op_vec,
   output logic [31:0]   op_a,
   output logic [31:0]   op_b,
   output logic [31:0]   op_c,
   output logic [31:0]   op_d
);

`ifdef ALU_OPC_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

   state_t        state;
   logic [AW-1:0] addr [4];
   logic [31:0]   slot [4];
   logic [2:0]    n;
   logic [2:0]    iss;
   logic [2:0]    cap;
   // iss_v/iss_z describe the current issue cycle; cap_v/cap_z the following data cycle
   logic          iss_v, iss_z, cap_v, cap_z;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return R0Z && (a == '0);
   endfunction

   assign op_a = slot[0];
   assign op_b = slot[1];
   assign op_c = slot[2];
   assign op_d = slot[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b0;
         rf_en     <= 1'b0;
         rf_addr   <= '0;
         op_valid  <= 1'b0;
         op_form   <= 1'b0;
         op_vec    <= 2'd0;
         n         <= 3'd4;
         iss       <= 3'd0;
         cap       <= 3'd0;
         iss_v     <= 1'b0;
         iss_z     <= 1'b0;
         cap_v     <= 1'b0;
         cap_z     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            addr[i] <= '0;
            slot[i] <= '0;
         end
      end else begin
         cap_v   <= iss_v;
         cap_z   <= iss_z;
         iss_v   <= 1'b0;
         iss_z   <= 1'b0;
         rf_en   <= 1'b0;
         rf_addr <= '0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  op_form   <= req_form;
                  op_vec    <= req_vec;
                  n         <= (req_form && req_vec != 2'd3) ? 3'd3 : 3'd4;
                  addr[0]   <= req_ra;
                  addr[1]   <= req_rb;
                  addr[2]   <= req_rc;
                  addr[3]   <= req_rd;
                  for (int i = 0; i < 4; i++) slot[i] <= '0;
                  // slot A is issued on the accept edge so rf_en is high in cycle 1
                  iss_v     <= 1'b1;
                  iss_z     <= is_zero(req_ra);
                  rf_en     <= !is_zero(req_ra);
                  rf_addr   <= req_ra;
                  iss       <= 3'd1;
                  cap       <= 3'd0;
                  state     <= READ;
               end
            end
            READ: begin
               if (iss < n) begin
                  iss_v   <= 1'b1;
                  iss_z   <= is_zero(addr[iss[1:0]]);
                  rf_en   <= !is_zero(addr[iss[1:0]]);
                  rf_addr <= addr[iss[1:0]];
                  iss     <= iss + 3'd1;
               end
               if (cap_v) begin
                  slot[cap[1:0]] <= cap_z ? 32'd0 : rf_rdata;
                  cap            <= cap + 3'd1;
                  if (cap == n - 3'd1) begin
                     op_valid <= 1'b1;
                     state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (op_ready) begin
                  op_valid  <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Self-checking bench for alu_operand_collector with a behavioural 1-cycle register file.
// Honours ALU_OPC_R0_ZERO_EN the same way the design does.
module tb_alu_operand_collector;
   localparam int unsigned AW = 5;

`ifdef ALU_OPC_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   typedef struct {
      logic        form;
      logic [1:0]  vec;
      logic [31:0] a, b, c, d;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_form = 1'b0;
   logic [1:0]    req_vec = 2'd0;
   logic [AW-1:0] req_ra = '0, req_rb = '0, req_rc = '0, req_rd = '0;
   logic          rf_en;
   logic [AW-1:0] rf_addr;
   logic [31:0]   rf_rdata = 32'd0;
   logic          op_valid;
   logic          op_ready = 1'b0;
   logic          op_form;
   logic [1:0]    op_vec;
   logic [31:0]   op_a, op_b, op_c, op_d;

   logic [31:0]   mem [32];
   exp_t          exp_q [$];
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   // Register file: data follows rf_en by one cycle; idle cycles return a poison value.
   always @(posedge clk) begin
      if (rf_en) rf_rdata <= mem[rf_addr];
      else       rf_rdata <= 32'hDEADBEEF;
   end

   alu_operand_collector #(.AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_form(req_form), .req_vec(req_vec),
      .req_ra(req_ra), .req_rb(req_rb), .req_rc(req_rc), .req_rd(req_rd),
      .rf_en(rf_en), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_form(op_form), .op_vec(op_vec),
      .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic zr(input logic [AW-1:0] a);
      return R0Z && (a == '0);
   endfunction

   task automatic send(input logic form, input logic [1:0] vec,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rc, input logic [AW-1:0] rd,
                       input int bp);
      logic [AW-1:0] ad [4];
      logic [31:0]   v [4];
      int            n;
      int            t;
      exp_t          e;
      exp_t          h;
      logic          en_exp;
      logic [AW-1:0] addr_exp;
      ad[0] = ra; ad[1] = rb; ad[2] = rc; ad[3] = rd;
      n = (form && vec != 2'd3) ? 3 : 4;
      for (int i = 0; i < 4; i++)
         v[i] = (i < n && !zr(ad[i])) ? mem[ad[i]] : 32'd0;
      e.form = form; e.vec = vec; e.a = v[0]; e.b = v[1]; e.c = v[2]; e.d = v[3];
      exp_q.push_back(e);

      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("req_ready_before_accept", 64'(req_ready), 64'd1);

      req_valid = 1'b1; req_form = form; req_vec = vec;
      req_ra = ra; req_rb = rb; req_rc = rc; req_rd = rd;
      @(posedge clk);
      #1 req_valid = 1'b0;

      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         en_exp = 1'b0;
         addr_exp = '0;
         if (k <= n) begin
            en_exp = !zr(ad[k-1]);
            addr_exp = ad[k-1];
         end
         check("rf_en", 64'(rf_en), 64'(en_exp));
         check("rf_addr", 64'(rf_addr), 64'(addr_exp));
         check("op_valid_latency", 64'(op_valid), 64'(k == n + 2));
      end

      // Backpressure: hold with stray request pulses that must be ignored
      for (int j = 0; j < bp; j++) begin
         req_valid = (j % 2 == 0);
         req_ra = 5'd31;
         @(negedge clk);
         check("hold_valid", 64'(op_valid), 64'd1);
         check("hold_ready", 64'(req_ready), 64'd0);
         check("hold_rf_en", 64'(rf_en), 64'd0);
         check("hold_ab", {op_a, op_b}, {e.a, e.b});
         check("hold_cd", {op_c, op_d}, {e.c, e.d});
      end
      req_valid = 1'b0;

      op_ready = 1'b1;
      if (!op_valid) begin
         vectors++;
         miscompares++;
         $display("FAIL op_valid_timeout got=0 exp=1 at %0t", $time);
      end
      h = exp_q.pop_front();
      check("op_a", 64'(op_a), 64'(h.a));
      check("op_b", 64'(op_b), 64'(h.b));
      check("op_c", 64'(op_c), 64'(h.c));
      check("op_d", 64'(op_d), 64'(h.d));
      check("op_form", 64'(op_form), 64'(h.form));
      check("op_vec", 64'(op_vec), 64'(h.vec));
      @(posedge clk);
      #1 op_ready = 1'b0;
      check("release_valid", 64'(op_valid), 64'd0);
      check("release_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++)
         mem[i] = (i < 16) ? 32'h11 * 32'(i) : ($urandom | 32'h1);
      mem[0] = 32'hDEADBEEF;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_op_valid", 64'(op_valid), 64'd0);
      check("rst_rf", {31'd0, rf_en, 27'(rf_addr)}, 64'd0);
      check("rst_form_vec", {61'd0, op_form, op_vec}, 64'd0);
      check("rst_ops", {op_a ^ op_b, op_c ^ op_d}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_req_ready", 64'(req_ready), 64'd1);

      send(1'b0, 2'd0, 5'd1, 5'd2, 5'd3, 5'd4, 0);
      send(1'b1, 2'd2, 5'd5, 5'd6, 5'd7, 5'd9, 0);
      send(1'b1, 2'd3, 5'd1, 5'd2, 5'd3, 5'd4, 0);
      send(1'b0, 2'd1, 5'd3, 5'd3, 5'd3, 5'd3, 10);

      // Reset in the middle of READ
      @(negedge clk);
      req_valid = 1'b1; req_form = 1'b0; req_vec = 2'd2;
      req_ra = 5'd8; req_rb = 5'd9; req_rc = 5'd10; req_rd = 5'd11;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_op_valid", 64'(op_valid), 64'd0);
      check("midrst_rf_en", 64'(rf_en), 64'd0);
      check("midrst_ops", {op_a, op_b}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      check("midrst_rf_en_after", 64'(rf_en), 64'd0);
      check("midrst_op_valid_after", 64'(op_valid), 64'd0);
      send(1'b1, 2'd0, 5'd12, 5'd13, 5'd14, 5'd15, 0);

      // Register 0 handling
      send(1'b0, 2'd2, 5'd0, 5'd5, 5'd0, 5'd6, 2);

      for (int r = 0; r < 8; r++)
         send(1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), int'($urandom_range(0, 3)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
